booth_mult_arbiter: RTL and testbench
=====================================

Name: booth_mult_arbiter

Overview:
- Shares one fully pipelined Booth multiplier between NUM_REQ requesters, for example convolution lanes in the CNN datapath.
- Each cycle it grants at most one request in round-robin order and drives the operands into the multiplier.
- It tracks the requester ID of each issued product through a fixed-latency tag pipeline.
- It routes each result back to the issuing requester with a one-cycle valid pulse.

Parameters:
NUM_REQ, 4, number of requesters (2..8)
OP_W, 8, operand width, two's complement signed
RES_W, 16, product width, equal to 2*OP_W
MULT_LAT, 2, multiplier latency in cycles from operand capture to valid mult_p
ACC_W, 24, accumulator width; used only when BOOTH_ARB_ACC_EN is defined

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous reset, active-high
req_valid  in  NUM_REQ  per-requester request
req_a  in  NUM_REQ*OP_W  packed multiplicands; requester i occupies [i*OP_W +: OP_W]
req_b  in  NUM_REQ*OP_W  packed multipliers; same packing as req_a
req_last  in  NUM_REQ  marks the final product of an accumulation (ACC feature only; ignored otherwise)
req_grant  out  NUM_REQ  one-hot grant; the request is consumed this cycle
mult_a  out  OP_W  multiplicand to the multiplier
mult_b  out  OP_W  multiplier operand to the multiplier
mult_issue  out  1  operands on mult_a/mult_b are valid this cycle
mult_p  in  RES_W  multiplier product, valid MULT_LAT cycles after mult_issue
rsp_valid  out  NUM_REQ  one-hot result valid
rsp_data  out  RES_W  product (or ACC_W accumulator sum with the feature; sign-extended/sized to max(RES_W,ACC_W))
busy  out  1  at least one product in flight

Behaviour:
- Reset (async, rst=1):
  - req_grant=0, mult_issue=0, mult_a=0, mult_b=0, rsp_valid=0, rsp_data=0, busy=0.
  - Round-robin pointer=0 and all tag pipeline entries invalid.
  - Products in flight when reset asserts are discarded; no rsp_valid is produced for them after reset releases.
- Arbitration (combinational grant, registered issue):
  - Search starts at the pointer and wraps modulo NUM_REQ; the first i with req_valid[i]=1 wins.
  - req_grant[i] is asserted in the same cycle. Requesters hold req_valid and their operands stable until granted, then may present the next request the following cycle.
  - On a grant the pointer becomes (i+1) mod NUM_REQ. With no request, the pointer holds.
  - Throughput is one grant per cycle. A single requester held continuously is granted every cycle.
- Issue:
  - On the clock edge after a grant: mult_a/mult_b are the granted operands and mult_issue=1 for exactly one cycle.
  - Tag pipeline stage 0 is loaded with {valid, id, last}.
- Tag pipeline:
  - MULT_LAT+1 stages from grant edge to result, shifting every cycle with no stall.
  - When the final stage is valid: rsp_valid[id]=1 and rsp_data=mult_p, registered.
  - Total latency: grant cycle to rsp_valid is MULT_LAT+2 cycles (MULT_LAT=2 gives 4).
  - Results return in grant order; there is no response backpressure.
- busy=1 while any tag stage is valid. busy drops the cycle after the last rsp_valid.
- Signed arithmetic: operands pass through unmodified; mult_p is treated as signed RES_W.
- Simultaneous events: a new grant and a response for a different or the same requester in the same cycle are both legal and independent.

Optional Feature:
- Macro: BOOTH_ARB_ACC_EN.
- Defined:
  - Each requester has an ACC_W signed accumulator, reset to 0.
  - On each returning product for id, acc[id] += sign-extended mult_p. Overflow wraps modulo 2^ACC_W.
  - rsp_valid[id] pulses only when the returning tag has last=1. rsp_data is then the sum including that product, and acc[id] clears to 0 in the same cycle.
  - Non-last products produce no rsp_valid.
- Undefined:
  - No accumulators; req_last is ignored.
  - Every product produces rsp_valid with rsp_data=mult_p.

Test Plan:
- Reset then idle, req_valid=0 for 10 cycles -> all outputs 0, busy=0, pointer 0 (first later request from req 0 and 3 grants req 0).
- All 4 requesters held valid for 8 cycles -> grants 0,1,2,3,0,1,2,3 one per cycle; rsp_valid one-hot in the same order, each 4 cycles after its grant.
- Req 2 alone, a=-7, b=13 -> req_grant=0100, mult_issue next cycle with operands -7/13, rsp_valid[2] with rsp_data=-91 (16'hFFA5) 4 cycles after grant.
- Req 1 and req 3 granted back-to-back, rst asserted 2 cycles later for 1 cycle -> outputs clear immediately, no rsp_valid after release, busy=0.
- Boundary operands -128*-128 and -128*127 -> rsp_data 16384 and -16256.
- BOOTH_ARB_ACC_EN, req 0 issues 3*4, 5*-2, 7*7 (last on the third) -> single rsp_valid[0] with rsp_data=51, and acc[0] is 0 after.

Source files
------------

// File: rtl/booth_mult_arbiter.sv
// booth_mult_arbiter
// ------------------
// Shares one fully pipelined signed multiplier between NUM_REQ requesters.
// Each cycle at most one request is granted in round-robin order, and the
// granted operands are registered onto the multiplier interface. A tag
// pipeline of MULT_LAT+1 stages follows each product. When a tag reaches
// the final stage, the product on mult_p_i is routed back to its requester
// as a registered one-cycle pulse. The latency from grant to response is
// MULT_LAT+2 cycles.
//
// Optional feature macro: BOOTH_ARB_ACC_EN
//   When this macro is defined, each requester owns an ACC_W-bit signed
//   accumulator. Every returning product is added to that accumulator.
//   A response is produced only for a product tagged "last". That response
//   carries the running sum, and the accumulator then clears to 0.
//   When the macro is undefined, req_last_i is ignored and every product is
//   returned as it arrives.
//
// Ports:
//   clk           clock, rising edge
//   rst           asynchronous reset, active-high
//   req_valid_i   [NUM_REQ]       per-requester request
//   req_a_i       [NUM_REQ*OP_W]  packed multiplicands, requester i at [i*OP_W +: OP_W]
//   req_b_i       [NUM_REQ*OP_W]  packed multipliers, same packing
//   req_last_i    [NUM_REQ]       final product of an accumulation (accumulator build only)
//   req_grant_o   [NUM_REQ]       one-hot grant; the request is consumed this cycle
//   mult_a_o      [OP_W]          multiplicand to the multiplier
//   mult_b_o      [OP_W]          multiplier operand to the multiplier
//   mult_issue_o                  mult_a_o/mult_b_o are valid this cycle
//   mult_p_i      [RES_W]         product, valid MULT_LAT cycles after mult_issue_o
//   rsp_valid_o   [NUM_REQ]       one-hot result valid
//   rsp_data_o    [DATA_W]        product, or accumulator sum in the accumulator build
//   busy_o                        at least one product in flight
module booth_mult_arbiter #(
    parameter int NUM_REQ  = 4,
    parameter int OP_W     = 8,
    parameter int RES_W    = 16,
    parameter int MULT_LAT = 2,
    parameter int ACC_W    = 24,
`ifdef BOOTH_ARB_ACC_EN
    localparam int DATA_W  = (ACC_W > RES_W) ? ACC_W : RES_W
`else
    localparam int DATA_W  = RES_W
`endif
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [NUM_REQ-1:0]      req_valid_i,
    input  logic [NUM_REQ*OP_W-1:0] req_a_i,
    input  logic [NUM_REQ*OP_W-1:0] req_b_i,
    input  logic [NUM_REQ-1:0]      req_last_i,
    output logic [NUM_REQ-1:0]      req_grant_o,
    output logic [OP_W-1:0]         mult_a_o,
    output logic [OP_W-1:0]         mult_b_o,
    output logic                    mult_issue_o,
    input  logic [RES_W-1:0]        mult_p_i,
    output logic [NUM_REQ-1:0]      rsp_valid_o,
    output logic [DATA_W-1:0]       rsp_data_o,
    output logic                    busy_o
);

    localparam int IDX_W = $clog2(NUM_REQ);
    localparam int FIN   = MULT_LAT;

    // ------------------------------------------------------------------
    // Operand unpacking
    // ------------------------------------------------------------------
    logic [OP_W-1:0] a_arr [NUM_REQ];
    logic [OP_W-1:0] b_arr [NUM_REQ];

    for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_unpack
        assign a_arr[gi] = req_a_i[gi*OP_W +: OP_W];
        assign b_arr[gi] = req_b_i[gi*OP_W +: OP_W];
    end

    // ------------------------------------------------------------------
    // Round-robin arbitration (combinational grant)
    // ------------------------------------------------------------------
    logic [IDX_W-1:0] ptr_q, ptr_d;
    logic             gnt_any;
    logic [IDX_W-1:0] gnt_idx;

    always_comb begin
        int               cand;
        logic [IDX_W-1:0] cand_idx;
        gnt_any  = 1'b0;
        gnt_idx  = '0;
        cand     = 0;
        cand_idx = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            cand     = (int'(ptr_q) + k) % NUM_REQ;
            cand_idx = IDX_W'(cand);
            if (!gnt_any && req_valid_i[cand_idx]) begin
                gnt_any = 1'b1;
                gnt_idx = cand_idx;
            end
        end
        // The grant is combinational, so it must be gated explicitly while
        // reset is held.
        if (rst) begin
            gnt_any = 1'b0;
        end
    end

    always_comb begin
        ptr_d = ptr_q;
        if (gnt_any) begin
            ptr_d = (gnt_idx == IDX_W'(NUM_REQ - 1)) ? '0 : gnt_idx + 1'b1;
        end
    end

    for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_grant
        assign req_grant_o[gi] = gnt_any && (gnt_idx == IDX_W'(gi));
    end

    // ------------------------------------------------------------------
    // Issue registers and tag pipeline
    // ------------------------------------------------------------------
    logic [OP_W-1:0]  mult_a_q, mult_b_q;
    logic             mult_issue_q;
    logic [FIN:0]     tag_valid_q;
    logic [FIN:0]     tag_last_q;
    logic [IDX_W-1:0] tag_id_q [FIN+1];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr_q        <= '0;
            mult_a_q     <= '0;
            mult_b_q     <= '0;
            mult_issue_q <= 1'b0;
            tag_valid_q  <= '0;
            tag_last_q   <= '0;
            for (int s = 0; s <= FIN; s++) begin
                tag_id_q[s] <= '0;
            end
        end else begin
            ptr_q        <= ptr_d;
            mult_issue_q <= gnt_any;
            if (gnt_any) begin
                mult_a_q <= a_arr[gnt_idx];
                mult_b_q <= b_arr[gnt_idx];
            end
            // Stage 0 is aligned with mult_issue_o. Stage FIN is aligned
            // with the product on mult_p_i.
            tag_valid_q[0] <= gnt_any;
            tag_last_q[0]  <= req_last_i[gnt_idx];
            tag_id_q[0]    <= gnt_idx;
            for (int s = 1; s <= FIN; s++) begin
                tag_valid_q[s] <= tag_valid_q[s-1];
                tag_last_q[s]  <= tag_last_q[s-1];
                tag_id_q[s]    <= tag_id_q[s-1];
            end
        end
    end

    // ------------------------------------------------------------------
    // Result routing
    // ------------------------------------------------------------------
    logic               fin_valid;
    logic [IDX_W-1:0]   fin_id;
    logic               rsp_fire;
    logic [DATA_W-1:0]  rsp_value;
    logic [NUM_REQ-1:0] rsp_valid_q;
    logic [DATA_W-1:0]  rsp_data_q;

    assign fin_valid = tag_valid_q[FIN];
    assign fin_id    = tag_id_q[FIN];

`ifdef BOOTH_ARB_ACC_EN
    logic [ACC_W-1:0] acc_q [NUM_REQ];
    logic [ACC_W-1:0] acc_sum;

    // The sum wraps modulo 2^ACC_W.
    assign acc_sum = acc_q[fin_id] + ACC_W'($signed(mult_p_i));

    always_comb begin
        rsp_fire  = fin_valid && tag_last_q[FIN];
        rsp_value = DATA_W'($signed(acc_sum));
    end

    for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_acc
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                acc_q[gi] <= '0;
            end else if (fin_valid && (fin_id == IDX_W'(gi))) begin
                // The accumulator clears on the cycle its sum is reported.
                acc_q[gi] <= tag_last_q[FIN] ? '0 : acc_sum;
            end
        end
    end
`else
    always_comb begin
        rsp_fire  = fin_valid;
        rsp_value = mult_p_i;
    end

    // The last flag rides the tag pipeline but has no consumer in this build.
    logic unused_ok;
    assign unused_ok = ^{tag_last_q[FIN], (ACC_W > 0)};
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rsp_valid_q <= '0;
            rsp_data_q  <= '0;
        end else begin
            rsp_valid_q <= rsp_fire ? (NUM_REQ'(1) << fin_id) : '0;
            if (rsp_fire) begin
                rsp_data_q <= rsp_value;
            end
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign mult_a_o     = mult_a_q;
    assign mult_b_o     = mult_b_q;
    assign mult_issue_o = mult_issue_q;
    assign rsp_valid_o  = rsp_valid_q;
    assign rsp_data_o   = rsp_data_q;
    // busy_o also covers the response cycle, so it drops one cycle after
    // the final rsp_valid_o pulse.
    assign busy_o       = (|tag_valid_q) || (|rsp_valid_q);

endmodule

// File: tb/tb_booth_mult_arbiter.sv
module tb_booth_mult_arbiter;

    localparam int NR  = 4;
    localparam int OW  = 8;
    localparam int RW  = 16;
    localparam int LAT = 2;
`ifdef BOOTH_ARB_ACC_EN
    localparam int DW  = 24;
`else
    localparam int DW  = 16;
`endif

    logic                clk = 1'b0;
    logic                rst = 1'b1;
    logic [NR-1:0]       req_valid = '0;
    logic [NR*OW-1:0]    req_a = '0;
    logic [NR*OW-1:0]    req_b = '0;
    logic [NR-1:0]       req_last = '1;
    logic [NR-1:0]       req_grant;
    logic [OW-1:0]       mult_a, mult_b;
    logic                mult_issue;
    logic [RW-1:0]       mult_p;
    logic [NR-1:0]       rsp_valid;
    logic [DW-1:0]       rsp_data;
    logic                busy;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    booth_mult_arbiter #(
        .NUM_REQ(NR), .OP_W(OW), .RES_W(RW), .MULT_LAT(LAT), .ACC_W(24)
    ) dut (
        .clk(clk), .rst(rst),
        .req_valid_i(req_valid), .req_a_i(req_a), .req_b_i(req_b),
        .req_last_i(req_last), .req_grant_o(req_grant),
        .mult_a_o(mult_a), .mult_b_o(mult_b), .mult_issue_o(mult_issue),
        .mult_p_i(mult_p), .rsp_valid_o(rsp_valid), .rsp_data_o(rsp_data),
        .busy_o(busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // External pipelined multiplier with a latency of two cycles
    logic signed [RW-1:0] p1 = '0, p2 = '0;
    always @(posedge clk) begin
        p1 <= $signed(mult_a) * $signed(mult_b);
        p2 <= p1;
    end
    assign mult_p = p2;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        checks++;
        assert (obs === exp_v) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
        end
    endtask

    function automatic logic signed [RW-1:0] prod(input logic signed [OW-1:0] a,
                                                   input logic signed [OW-1:0] b);
        logic signed [RW-1:0] p;
        p = a * b;
        return p;
    endfunction

    // ------------------------------------------------------------------
    // Reference model and scoreboard
    // ------------------------------------------------------------------
    typedef struct {
        int            id;
        logic [DW-1:0] data;
        int            due;
    } exp_t;

    exp_t               sb[$];
    int                 ptr_m  = 0;
    int                 g_last = -100;
    logic               prev_issue = 1'b0;
    logic [OW-1:0]      prev_a = '0, prev_b = '0;
    logic signed [DW-1:0] acc_m [NR];

    always @(negedge clk) begin
        if (rst) begin
            chk("rst_grant", 32'(req_grant), 32'd0);
            chk("rst_issue", 32'(mult_issue), 32'd0);
            chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
            chk("rst_rsp_data", 32'(rsp_data), 32'd0);
            chk("rst_busy", 32'(busy), 32'd0);
            chk("rst_mult_ab", {16'd0, mult_a, mult_b}, 32'd0);
            sb.delete();
            ptr_m      = 0;
            g_last     = -100;
            prev_issue = 1'b0;
            for (int i = 0; i < NR; i++) acc_m[i] = '0;
        end else begin
            int          gid;
            logic        found;
            logic [NR-1:0] exp_gnt;
            exp_t        e;

            chk("issue", 32'(mult_issue), 32'(prev_issue));
            if (prev_issue) begin
                chk("issue_a", 32'(mult_a), 32'(prev_a));
                chk("issue_b", 32'(mult_b), 32'(prev_b));
            end

            chk("busy", 32'(busy), 32'((cyc >= g_last + 1) && (cyc <= g_last + LAT + 2)));

            if (sb.size() > 0 && sb[0].due == cyc) begin
                e = sb.pop_front();
                chk("rsp_valid", 32'(rsp_valid), 32'(1) << e.id);
                chk("rsp_data", 32'(rsp_data), 32'(e.data));
                $display("rsp id=%0d data=%0h cyc=%0d", e.id, rsp_data, cyc);
            end else begin
                chk("rsp_idle", 32'(rsp_valid), 32'd0);
            end

            found   = 1'b0;
            gid     = 0;
            exp_gnt = '0;
            for (int k = 0; k < NR; k++) begin
                int c;
                c = (ptr_m + k) % NR;
                if (!found && req_valid[c]) begin
                    found = 1'b1;
                    gid   = c;
                end
            end
            if (found) exp_gnt[gid] = 1'b1;
            chk("grant", 32'(req_grant), 32'(exp_gnt));

            prev_issue = found;
            if (found) begin
                logic signed [RW-1:0] p;
                prev_a = req_a[gid*OW +: OW];
                prev_b = req_b[gid*OW +: OW];
                p      = prod(prev_a, prev_b);
                g_last = cyc;
                ptr_m  = (gid + 1) % NR;
                $display("grant id=%0d a=%0d b=%0d cyc=%0d", gid,
                         $signed(prev_a), $signed(prev_b), cyc);
`ifdef BOOTH_ARB_ACC_EN
                acc_m[gid] = acc_m[gid] + DW'(p);
                if (req_last[gid]) begin
                    sb.push_back('{gid, acc_m[gid], cyc + LAT + 2});
                    acc_m[gid] = '0;
                end
`else
                sb.push_back('{gid, DW'(p), cyc + LAT + 2});
`endif
            end
        end
    end

    // ------------------------------------------------------------------
    // Directed stimulus helpers
    // ------------------------------------------------------------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_op(input int id, input logic [OW-1:0] a, input logic [OW-1:0] b);
        req_a[id*OW +: OW] = a;
        req_b[id*OW +: OW] = b;
    endtask

    // One request from one requester, then a bounded wait for its response.
    task automatic single(input string tag, input int id, input logic [OW-1:0] a,
                          input logic [OW-1:0] b, input logic [DW-1:0] exp_d);
        int  g;
        bit  seen;
        step();
        set_op(id, a, b);
        req_valid     = '0;
        req_valid[id] = 1'b1;
        @(negedge clk);
        g = cyc;
        chk({tag, "_grant"}, 32'(req_grant), 32'(1) << id);
        step();
        req_valid = '0;
        seen = 1'b0;
        for (int i = 0; i < 10 && !seen; i++) begin
            @(negedge clk);
            if (rsp_valid[id]) begin
                seen = 1'b1;
                chk({tag, "_latency"}, 32'(cyc - g), 32'(LAT + 2));
                chk({tag, "_data"}, 32'(rsp_data), 32'(exp_d));
            end
        end
        if (!seen) chk({tag, "_timeout"}, 32'd0, 32'd1);
    endtask

    logic signed [DW-1:0] ev;
    logic [NR-1:0]        pend;

    initial begin
        // Reset, then stay idle
        repeat (3) step();
        rst = 1'b0;
        repeat (10) step();
        chk("idle_busy", 32'(busy), 32'd0);
        chk("idle_rsp", 32'(rsp_valid), 32'd0);

        // The pointer starts at 0, so requesters 0 and 3 together grant 0
        set_op(0, 8'd1, 8'd2);
        set_op(3, 8'd3, 8'd4);
        req_valid = 4'b1001;
        @(negedge clk);
        chk("ptr0_grant", 32'(req_grant), 32'b0001);
        step();
        req_valid = 4'b1000;
        step();
        req_valid = '0;
        repeat (6) step();

        // All four requesters are held valid for 8 cycles
        req_valid = 4'b1111;
        for (int k = 0; k < 8; k++) begin
            for (int i = 0; i < NR; i++) set_op(i, OW'($urandom), OW'($urandom));
            @(negedge clk);
            chk("rr_order", 32'(req_grant), 32'(1) << (k % NR));
            step();
        end
        req_valid = '0;
        repeat (6) step();

        // Requester 2 alone: -7 * 13
        ev = -91;
        single("neg", 2, 8'hF9, 8'd13, ev);

        // Boundary operands
        ev = 16384;
        single("bnd_nn", 0, 8'h80, 8'h80, ev);
        ev = -16256;
        single("bnd_np", 1, 8'h80, 8'h7F, ev);

        // Two back-to-back grants, then reset while they are in flight
        step();
        set_op(1, 8'd5, 8'd6);
        set_op(3, 8'd7, 8'd8);
        req_valid = 4'b1010;
        @(negedge clk);
        pend = req_valid & ~req_grant;
        step();
        req_valid = pend;
        step();
        req_valid = '0;
        step();
        rst = 1'b1;
        #1;
        chk("arst_rsp", 32'(rsp_valid), 32'd0);
        chk("arst_issue", 32'(mult_issue), 32'd0);
        chk("arst_busy", 32'(busy), 32'd0);
        step();
        rst = 1'b0;
        repeat (8) step();
        chk("post_rst_busy", 32'(busy), 32'd0);

`ifdef BOOTH_ARB_ACC_EN
        // Accumulation of 3*4 + 5*-2 + 7*7 = 51, reported once
        req_valid = 4'b0001;
        req_last  = 4'b0000;
        set_op(0, 8'd3, 8'd4);
        step();
        set_op(0, 8'd5, 8'hFE);
        step();
        set_op(0, 8'd7, 8'd7);
        req_last = 4'b0001;
        step();
        req_valid = '0;
        req_last  = '1;
        repeat (3) begin
            @(negedge clk);
            chk("acc_quiet", 32'(rsp_valid), 32'd0);
            step();
        end
        @(negedge clk);
        chk("acc_rsp", 32'(rsp_valid), 32'b0001);
        chk("acc_sum", 32'(rsp_data), 32'd51);
        repeat (4) step();
        // The accumulator has cleared, so a lone last product returns as-is
        ev = 6;
        single("acc_clr", 0, 8'd2, 8'd3, ev);
`endif

        repeat (8) step();
        chk("sb_empty", 32'(sb.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
